log_antilog_decoder: RTL
========================

// Module: log_antilog_decoder
// PURPOSE
//  Inverse of the leading-one detect/log-encode path of the log multiplier. Takes a log-domain
//  value {k, f} (integer characteristic k, fraction f) and rebuilds the linear value
//  floor((1 + f/2^FRAC_W) * 2^k) using Mitchell's approximation.
//  Sits after the log-sum adder and drives the final product out of the multiplier.
//  The datapath is a 2-stage valid/ready pipeline.
// PARAMETERS
//  OUT_W   16                    width of the linear output (product width)
//  FRAC_W  7                     fraction width of the log input
//  K_W     $clog2(OUT_W)+1 (=5)  characteristic width; its values can exceed OUT_W-1
// PORTS
//  clk        in   1             single clock; all logic is rising-edge
//  rst        in   1             synchronous, active-high reset
//  in_valid   in   1             input beat valid
//  in_ready   out  1             block accepts the beat when in_valid & in_ready
//  in_k       in   K_W           characteristic (leading-one position of the sum)
//  in_frac    in   FRAC_W        mantissa fraction
//  in_zero    in   1             an operand was zero (LOD or_out low); forces a result of 0
//  out_valid  out  1             result valid
//  out_ready  in   1             downstream accepts the result when out_valid & out_ready
//  out_data   out  OUT_W         linear result
//  out_ovf    out  1             result saturated, valid with out_data
// BEHAVIOUR
//  Reset (clk edge with rst=1):
//  - s1_valid and s2_valid are cleared.
//  - out_valid=0, out_data=0, out_ovf=0.
//  - in_ready=1 in the first cycle after reset.
//  - Any beats in flight are dropped.
//  Stage 1 (capture/decode), on an accepted beat:
//  - mant = {1'b1, in_frac}, FRAC_W+1 bits.
//  - Registered: shift direction, shift amount, and the zero and ovf flags.
//  - left = (in_k >= FRAC_W); amt = left ? in_k-FRAC_W : FRAC_W-in_k.
//  - ovf = ~in_zero & (in_k > OUT_W-1).
//  Stage 2 (shift), priority order:
//  1. zero: out_data = 0, out_ovf = 0.
//  2. ovf: out_data = all ones, out_ovf = 1.
//  3. left: out_data = mant << amt; truncate to OUT_W (no bits are lost while k <= OUT_W-1).
//  4. else: out_data = mant >> amt. Truncate toward zero; fraction bits are discarded.
//  Handshake and latency:
//  - Latency is 2 cycles from accept to out_valid when not stalled.
//  - Throughput is 1 beat per cycle.
//  - adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2.
//  - in_ready = adv1. This is a combinational path from out_ready; no skid buffer.
//  - While out_valid & ~out_ready: out_data and out_ovf stay stable and are not overwritten.
//    Stage 1 holds its beat as well.
//  - When both stages are full and stalled, in_ready = 0.
//  - A beat is never dropped or duplicated. Beats leave in order.
//  - in_valid may drop without a handshake.
//  - Inputs are ignored when in_valid=0 or in_ready=0.
//  Simultaneous events:
//  - Accept in stage 1, stage 1->2 transfer and output pop can all happen in the same cycle.
//  - rst wins over every other event.
//  Data-path state:
//  - out_data/out_ovf update only when stage 2 loads.
//  - When stage 2 empties with no new beat, out_valid=0 and out_data keeps its last value.
//  Arithmetic:
//  - The block is unsigned only.
//  - in_frac is used as given; rounding, if any, is done upstream.
// TESTING
//  (OUT_W=16, FRAC_W=7)
//  - k=3, f=0x00 -> out_data=0x0008, ovf=0; out_valid exactly 2 cycles after accept.
//  - k=7, f=0x40 -> 0x00C0. k=14, f=0x7F -> 0x7F80. k=0, f=0x7F -> 0x0001 (truncation).
//  - k=16 -> 0xFFFF, ovf=1. k=31, in_zero=1 -> 0x0000, ovf=0 (zero beats overflow).
//  - Back-to-back beats with out_ready=0 for 5 cycles:
//    in_ready falls after 2 accepts, out_data holds stable.
//    On release the output order matches the input order, with no loss or duplication.
//  - Random in_valid/out_ready over 10k beats vs a reference model:
//    exact match, 1 beat/cycle when out_ready=1.
//  - Assert rst while both stages are full:
//    next cycle out_valid=0, out_data=0, in_ready=1; the next beat is processed normally.

Source files
------------

// File: rtl/log_antilog_decoder_if.sv
// Valid/ready bundle for the log-to-linear decoder: log-domain input beat and linear result.
// The slave modport is the decoder side; the master modport is the producer/consumer side.
interface log_antilog_decoder_if #(
    parameter int unsigned OutW  = 16,
    parameter int unsigned FracW = 7,
    parameter int unsigned KW    = $clog2(OutW) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [KW-1:0]    in_k;
    logic [FracW-1:0] in_frac;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [OutW-1:0]  out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_k, in_frac, in_zero, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_k, in_frac, in_zero, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/log_antilog_decoder.sv
// Mitchell antilog: rebuilds floor((1 + f/2^FracW) * 2^k) from a log-domain {k, f} beat.
// Two-stage valid/ready pipeline: stage 1 decodes shift/flags, stage 2 shifts and holds the result.
module log_antilog_decoder #(
    parameter int unsigned OutW  = 16,
    parameter int unsigned FracW = 7,
    parameter int unsigned KW    = $clog2(OutW) + 1
) (
    input logic                  clk,
    input logic                  rst,
    log_antilog_decoder_if.slave bus
);
    localparam int unsigned MantW = FracW + 1;

    logic             adv1;
    logic             adv2;
    logic             in_fire;

    logic             s1_valid;
    logic             s1_left;
    logic             s1_zero;
    logic             s1_ovf;
    logic [KW-1:0]    s1_amt;
    logic [FracW-1:0] s1_frac;

    logic             s2_valid;
    logic [OutW-1:0]  s2_data;
    logic             s2_ovf;

    logic             dec_left;
    logic [KW-1:0]    dec_amt;
    logic             dec_ovf;

    logic [OutW-1:0]  mant_w;
    logic [OutW-1:0]  shifted;
    logic [OutW-1:0]  res_data;
    logic             res_ovf;

    // Backpressure ripples combinationally from out_ready to in_ready; no skid buffer.
    always_comb begin
        adv2    = ~s2_valid | bus.out_ready;
        adv1    = ~s1_valid | adv2;
        in_fire = bus.in_valid & adv1;
    end

    always_comb begin
        dec_left = bus.in_k >= KW'(FracW);
        dec_amt  = dec_left ? (bus.in_k - KW'(FracW)) : (KW'(FracW) - bus.in_k);
        dec_ovf  = ~bus.in_zero & (bus.in_k > KW'(OutW - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_left  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_amt   <= '0;
            s1_frac  <= '0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (in_fire) begin
                s1_left <= dec_left;
                s1_zero <= bus.in_zero;
                s1_ovf  <= dec_ovf;
                s1_amt  <= dec_amt;
                s1_frac <= bus.in_frac;
            end
        end
    end

    // Left shifts cannot lose the leading one here: overflowing k values are diverted by s1_ovf.
    always_comb begin
        mant_w            = '0;
        mant_w[MantW-1:0] = {1'b1, s1_frac};
        shifted           = s1_left ? (mant_w << s1_amt) : (mant_w >> s1_amt);
        if (s1_zero) begin
            res_data = '0;
            res_ovf  = 1'b0;
        end else if (s1_ovf) begin
            res_data = '1;
            res_ovf  = 1'b1;
        end else begin
            res_data = shifted;
            res_ovf  = 1'b0;
        end
    end

    // The result registers only change when stage 2 loads, so a stalled output stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ovf   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= res_data;
                s2_ovf  <= res_ovf;
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_ovf   = s2_ovf;

endmodule
